// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - unified RAM arbiter for instruction fetch and load/store, with UART store path
//
// Shares one RAM read port and the RAM write port between the fetch unit
// (read-only) and the load/store unit (read/write with byte strobes).
// Grants are combinational. Read data returns registered one cycle after the grant.
// Region decode is on addr[31:24]:
//   LSU writes to 0x10 are sent as one byte to a UART handshake.
//   LSU writes to 0x11..0xFF go to RAM.
//   Other LSU writes are granted and dropped.
//
// Optional build macro: MEM_ARB_FAIR_EN. It adds fetch anti-starvation after
// STARVE_MAX consecutive contended LSU grants.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr/if_gnt           fetch request, address, combinational grant
//   if_rvalid/if_rdata              registered fetch read return
//   lsu_req/lsu_we/lsu_addr/
//   lsu_wdata/lsu_gnt               LSU request (we=0 read), combinational grant
//   lsu_rvalid/lsu_rdata            registered LSU read return
//   mem_raddr/mem_waddr/mem_wdata/
//   mem_wea/mem_rdata               RAM read port, RAM write port
//   uart_valid/uart_data/uart_ready byte-wide UART handshake
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        lsu_req,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wea,
  input  logic [31:0] mem_rdata,
  output logic        uart_valid,
  output logic [7:0]  uart_data,
  input  logic        uart_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    UART = 1'b1
  } state_t;

  state_t     state;
  logic       can_grant;
  logic       fetch_wins;
  logic [7:0] lsu_region;
  logic       lsu_write;
  logic       lsu_read_gnt;
  logic       lsu_ram_write;
  logic       lsu_uart_write;

  // Grants are also held off while reset is asserted, so every output reads 0 in reset.
  assign can_grant  = rst_n && (state == IDLE);
  assign lsu_region = lsu_addr[31:24];
  assign lsu_write  = |lsu_we;

  // The LSU has priority unless the starvation counter hands this contention to fetch.
  assign lsu_gnt = can_grant & lsu_req & ~(if_req & fetch_wins);
  assign if_gnt  = can_grant & if_req & (~lsu_req | fetch_wins);

  assign lsu_read_gnt   = lsu_gnt & ~lsu_write;
  assign lsu_ram_write  = lsu_gnt & lsu_write & (lsu_region > 8'h10);
  assign lsu_uart_write = lsu_gnt & lsu_write & (lsu_region == 8'h10);

  assign mem_raddr = if_gnt ? if_addr : (lsu_read_gnt ? lsu_addr : 32'h0);
  assign mem_waddr = lsu_ram_write ? lsu_addr  : 32'h0;
  assign mem_wdata = lsu_ram_write ? lsu_wdata : 32'h0;
  assign mem_wea   = lsu_ram_write ? lsu_we    : 4'h0;

  // The RAM updates mem_rdata at the negedge of the grant cycle.
  // Sampling at the closing posedge therefore gives a one-cycle read return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      uart_valid <= 1'b0;
      uart_data  <= 8'h0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= 32'h0;
    end else begin
      if_rvalid  <= if_gnt;
      lsu_rvalid <= lsu_read_gnt;
      if (if_gnt) begin
        if_rdata <= mem_rdata;
      end
      if (lsu_read_gnt) begin
        lsu_rdata <= mem_rdata;
      end
      case (state)
        IDLE: begin
          if (lsu_uart_write) begin
            state      <= UART;
            uart_valid <= 1'b1;
            uart_data  <= lsu_wdata[7:0];
          end
        end
        UART: begin
          if (uart_ready) begin
            state      <= IDLE;
            uart_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          uart_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  assign fetch_wins = (starve_cnt == STARVE_LIM);

  // Counts LSU wins while fetch is waiting. It saturates at the limit.
  // Any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (lsu_gnt && if_req && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  // Strict LSU priority. STARVE_MAX only matters when fairness is compiled in.
  // This expression is constant 0.
  assign fetch_wins = (STARVE_MAX < 0);
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-clock arbiter that shares the unified instruction/data RAM between the instruction-fetch unit (read-only) and the load/store unit (read/write with byte strobes). It sits between the pipeline and `ram`:
- drives one read port and the write port;
- routes stores in the 0x10xx_xxxx region to a byte-wide UART handshake instead of memory;
- drops stores to the 0x00xx_xxxx instruction region.

It provides one-cycle-latency registered read returns and optional anti-starvation for fetch.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive contended LSU grants after which fetch wins the next contention.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  combinational accept, same cycle as request.
- `if_rvalid`  out  1  registered one-cycle pulse, cycle after `if_gnt`.
- `if_rdata`  out  32  registered read data, valid with `if_rvalid`.
- `lsu_req`  in  1  LSU request; held with all LSU inputs until `lsu_gnt`.
- `lsu_we`  in  4  byte strobes; 0 = read, nonzero = write.
- `lsu_addr`  in  32  LSU byte address.
- `lsu_wdata`  in  32  store data.
- `lsu_gnt`  out  1  combinational accept.
- `lsu_rvalid`  out  1  registered pulse, cycle after a granted LSU read only.
- `lsu_rdata`  out  32  registered read data.
- `mem_raddr`  out  32  to `ram` raddr1; granted read address in grant cycle, else 0.
- `mem_waddr`  out  32  to `ram` waddr; granted write address in grant cycle, else 0.
- `mem_wdata`  out  32  to `ram` wdata.
- `mem_wea`  out  4  to `ram` wea; equals `lsu_we` only in a RAM-write grant cycle, else 0.
- `mem_rdata`  in  32  from `ram` rdata1; updated by RAM at negedge.
- `uart_valid`  out  1  UART byte valid.
- `uart_data`  out  8  UART byte.
- `uart_ready`  in  1  UART sink accepts when high with `uart_valid`.

## Operation
- FSM states:
  - IDLE: grants allowed.
  - UART: byte pending, no grants.
- IDLE arbitration, at most one grant per cycle:
  - LSU priority over fetch.
  - If only one requests, it wins.
- Grant classes, decoded on `addr[31:24]`:
  - Read, any region: `mem_raddr` = addr in grant cycle. At the end of that cycle, `mem_rdata` is captured into the requester's rdata register and its `rvalid` is set for exactly the next cycle.
  - Write with `addr[31:24]` > 0x10: `mem_waddr`/`mem_wdata`/`mem_wea` driven in grant cycle. No rvalid.
  - Write with `addr[31:24]` == 0x10: register `lsu_wdata[7:0]`, go to UART. No RAM write, no rvalid.
  - Write with `addr[31:24]` == 0x00: granted and silently dropped (`mem_wea`=0).
- UART state:
  - `uart_valid`=1 and `uart_data` = registered byte, held stable until `uart_ready`.
  - On `uart_valid & uart_ready`, return to IDLE; grants resume next cycle.
  - Both requesters stall in UART state; ordering is preserved.
- Back-to-back reads are permitted: a new grant may be issued in the same cycle an earlier `rvalid` is high.
- Reset values: all outputs 0, state IDLE, starve counter 0, rdata registers 0.
- Reset mid-UART: pending byte discarded; `uart_valid`=0 from the first cycle after the reset edge.
- `rvalid` pending at reset is suppressed.

## Timing
- Grant: combinational, same cycle as `req` in IDLE.
- Read latency: `rvalid`/`rdata` exactly 1 cycle after grant.
- RAM write: takes effect at negedge of the grant cycle.
- UART store: `uart_valid` rises 1 cycle after grant. If `uart_ready` is already high, IDLE is re-entered 2 cycles after grant.
- Read throughput: 1 per cycle. Each UART store costs at least 2 cycles.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - An internal counter increments on each LSU grant made while `if_req`=1.
  - It clears on any fetch grant, and holds otherwise.
  - When the counter equals `STARVE_MAX` and both request, fetch is granted and the counter clears.
  - The counter saturates at `STARVE_MAX`.
- Undefined: strict LSU priority; no counter logic is synthesized.

## Test plan
- Reset with `rst_n`=0 for 2 cycles, requests asserted → all outputs 0, no grants until `rst_n`=1.
- Fetch-only read of 0x0000_0004, RAM word 0x0000_0013 → `if_gnt` cycle k, `mem_raddr`=0x4; `if_rvalid`=1 with `if_rdata`=0x0000_0013 in cycle k+1 only.
- LSU write 0x2000_0010, `lsu_we`=4'b0011, data 0xAABB_CCDD, then read back → `mem_wea`=4'b0011 for one cycle; readback low half 0xCCDD.
- LSU store 0x1000_0000 data 0x41, `uart_ready` low 3 cycles then high → `uart_valid`=1 with `uart_data`=0x41 for 4 cycles; `if_req` held throughout gets no grant until 1 cycle after handshake.
- Store to 0x0000_0100 → `lsu_gnt`=1, `mem_wea`=0; later read of 0x100 returns the original contents.
- Both requesting continuously, `STARVE_MAX`=4:
  - with `MEM_ARB_FAIR_EN` → grant pattern L,L,L,L,F repeating;
  - without it → fetch never granted.
